// File: rtl/params_pkg.sv
// Shared pipeline constants: data-memory access sizes, trap cause codes and
// the data-memory access controller state type.
package params_pkg;

  localparam logic [2:0] DMEM_LOAD_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] DMEM_LOAD_SIZE_HALF  = 3'b001;
  localparam logic [2:0] DMEM_LOAD_SIZE_WORD  = 3'b010;
  localparam logic [2:0] DMEM_LOAD_SIZE_BYTEU = 3'b100;
  localparam logic [2:0] DMEM_LOAD_SIZE_HALFU = 3'b101;

  localparam logic [1:0] DMEM_STORE_SIZE_BYTE = 2'b00;
  localparam logic [1:0] DMEM_STORE_SIZE_HALF = 2'b01;
  localparam logic [1:0] DMEM_STORE_SIZE_WORD = 2'b10;

  localparam logic [30:0] TRAP_CODE_LOAD_ADDR_MISALIGNED  = 31'd4;
  localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT     = 31'd5;
  localparam logic [30:0] TRAP_CODE_STORE_ADDR_MISALIGNED = 31'd6;
  localparam logic [30:0] TRAP_CODE_STORE_ACCESS_FAULT    = 31'd7;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_REQ,
    DMEM_RESP,
    DMEM_DONE
  } dmem_state_t;

  function automatic logic [30:0] dmem_access_fault_code(input logic is_store);
    return is_store ? TRAP_CODE_STORE_ACCESS_FAULT : TRAP_CODE_LOAD_ACCESS_FAULT;
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane alignment: byte strobes, lane-replicated write data and the
// misalignment flag for a store of the given size at the given byte offset.
module store_align
  import params_pkg::*;
(
  input  logic [1:0]  store_type_i,
  input  logic [1:0]  addr_lsb2_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    wstrb_o      = 4'hf;
    wdata_o      = wdata_i;
    misaligned_o = (addr_lsb2_i != 2'b00);
    case (store_type_i)
      DMEM_STORE_SIZE_BYTE: begin
        wstrb_o      = 4'b0001 << addr_lsb2_i;
        wdata_o      = {4{wdata_i[7:0]}};
        misaligned_o = 1'b0;
      end
      DMEM_STORE_SIZE_HALF: begin
        wstrb_o      = 4'b0011 << addr_lsb2_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lsb2_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: runs the request/response
// handshake, stalls the pipeline while outstanding and raises memory traps.
module dmem_access_ctrl
  import params_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_is_store_i,
  input  logic [2:0]  req_load_type_i,
  input  logic [1:0]  req_store_type_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  load_type_o,
  output logic [1:0]  addr_lsb2_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  wmask_o,
  output logic        trap_o,
  output logic [30:0] trap_code_o,
  output logic        dmem_valid_o,
  input  logic        dmem_ready_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_wen_o,
  output logic [3:0]  dmem_wstrb_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  dmem_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic          killed_q;
  logic          dmem_valid_q, dmem_wen_q, trap_q;
  logic [31:0]   dmem_addr_q, dmem_wdata_q, rdata_q;
  logic [3:0]    dmem_wstrb_q, wmask_q;
  logic [2:0]    load_type_q;
  logic [1:0]    addr_lsb2_q;
  logic [30:0]   trap_code_q;

  logic [3:0]  sa_wstrb;
  logic [31:0] sa_wdata;
  logic        sa_misaligned;

  store_align u_store_align (
    .store_type_i (req_store_type_i),
    .addr_lsb2_i  (req_addr_i[1:0]),
    .wdata_i      (req_wdata_i),
    .wstrb_o      (sa_wstrb),
    .wdata_o      (sa_wdata),
    .misaligned_o (sa_misaligned)
  );

  logic accept, load_word_mis, load_half_mis;
  logic kill, timed_out, finish_rsp, finish_to;

  always_comb begin
    accept        = (state_q == DMEM_IDLE) && req_valid_i && !flush_i;
    load_word_mis = !req_is_store_i && (req_load_type_i == DMEM_LOAD_SIZE_WORD)
                    && (req_addr_i[1:0] != 2'b00);
    load_half_mis = !req_is_store_i && req_addr_i[0]
                    && ((req_load_type_i == DMEM_LOAD_SIZE_HALF) ||
                        (req_load_type_i == DMEM_LOAD_SIZE_HALFU));
    kill          = killed_q || flush_i;
    timed_out     = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
    finish_rsp    = ((state_q == DMEM_REQ) && dmem_ready_i && dmem_rvalid_i) ||
                    ((state_q == DMEM_RESP) && dmem_rvalid_i);
    finish_to     = !finish_rsp && timed_out &&
                    (((state_q == DMEM_REQ) && !dmem_ready_i) || (state_q == DMEM_RESP));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= '0;
      killed_q     <= 1'b0;
      dmem_valid_q <= 1'b0;
      dmem_wen_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wstrb_q <= '0;
      dmem_wdata_q <= '0;
      rdata_q      <= '0;
      load_type_q  <= '0;
      addr_lsb2_q  <= '0;
      wmask_q      <= '0;
      trap_q       <= 1'b0;
      trap_code_q  <= '0;
    end else begin
      case (state_q)
        DMEM_IDLE: if (accept) begin
          dmem_addr_q  <= {req_addr_i[31:2], 2'b00};
          dmem_wen_q   <= req_is_store_i;
          dmem_wstrb_q <= req_is_store_i ? sa_wstrb : 4'h0;
          dmem_wdata_q <= req_is_store_i ? sa_wdata : 32'h0;
          load_type_q  <= req_load_type_i;
          addr_lsb2_q  <= req_addr_i[1:0];
          wmask_q      <= '0;
          trap_q       <= 1'b0;
          trap_code_q  <= '0;
          killed_q     <= 1'b0;
          cnt_q        <= '0;
          if (req_is_store_i && sa_misaligned) begin
            trap_q      <= 1'b1;
            trap_code_q <= TRAP_CODE_STORE_ADDR_MISALIGNED;
            state_q     <= DMEM_DONE;
          end else if (load_word_mis) begin
            trap_q      <= 1'b1;
            trap_code_q <= TRAP_CODE_LOAD_ADDR_MISALIGNED;
            state_q     <= DMEM_DONE;
          end else if (load_half_mis) begin
            // load_unit raises this trap itself; only hand it a zero word
            rdata_q <= '0;
            state_q <= DMEM_DONE;
          end else begin
            dmem_valid_q <= 1'b1;
            state_q      <= DMEM_REQ;
          end
        end
        DMEM_REQ, DMEM_RESP: begin
          cnt_q <= cnt_q + 1'b1;
          if (flush_i) killed_q <= 1'b1;
          if (finish_rsp || finish_to) begin
            // a killed access drains the handshake but leaves no architectural trace
            dmem_valid_q <= 1'b0;
            killed_q     <= 1'b0;
            state_q      <= kill ? DMEM_IDLE : DMEM_DONE;
            if (!kill && finish_to) begin
              trap_q      <= 1'b1;
              trap_code_q <= dmem_access_fault_code(dmem_wen_q);
            end else if (!kill) begin
              if (!dmem_wen_q) rdata_q <= dmem_rdata_i;
              if (dmem_err_i) begin
                trap_q      <= 1'b1;
                trap_code_q <= dmem_access_fault_code(dmem_wen_q);
              end else if (dmem_wen_q) begin
                wmask_q <= dmem_wstrb_q;
              end
            end
          end else if ((state_q == DMEM_REQ) && dmem_ready_i) begin
            dmem_valid_q <= 1'b0;
            state_q      <= DMEM_RESP;
          end
        end
        DMEM_DONE: state_q <= DMEM_IDLE;
        default:   state_q <= DMEM_IDLE;
      endcase
    end
  end

  assign busy_o       = accept || (state_q == DMEM_REQ) || (state_q == DMEM_RESP);
  assign done_o       = (state_q == DMEM_DONE);
  assign load_type_o  = load_type_q;
  assign addr_lsb2_o  = addr_lsb2_q;
  assign rdata_o      = rdata_q;
  assign wmask_o      = wmask_q;
  assign trap_o       = trap_q;
  assign trap_code_o  = trap_code_q;
  assign dmem_valid_o = dmem_valid_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wen_o   = dmem_wen_q;
  assign dmem_wstrb_o = dmem_wstrb_q;
  assign dmem_wdata_o = dmem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: one default instance and one with a
// short timeout, both driven from the same request and bus inputs.
module tb_dmem_access_ctrl;
  import params_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_is_store = 1'b0, flush = 1'b0;
  logic [2:0]  req_load_type = '0;
  logic [1:0]  req_store_type = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0, dmem_err = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic        busy, done, trap, dvalid, dwen;
  logic [2:0]  load_type;
  logic [1:0]  lsb2;
  logic [31:0] rdata, daddr, dwdata;
  logic [3:0]  wmask, dwstrb;
  logic [30:0] tcode;

  logic        to_busy, to_done, to_trap, to_dvalid, to_dwen;
  logic [2:0]  to_load_type;
  logic [1:0]  to_lsb2;
  logic [31:0] to_rdata, to_daddr, to_dwdata;
  logic [3:0]  to_wmask, to_dwstrb;
  logic [30:0] to_tcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_is_store_i(req_is_store),
    .req_load_type_i(req_load_type), .req_store_type_i(req_store_type),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .flush_i(flush),
    .busy_o(busy), .done_o(done), .load_type_o(load_type), .addr_lsb2_o(lsb2),
    .rdata_o(rdata), .wmask_o(wmask), .trap_o(trap), .trap_code_o(tcode),
    .dmem_valid_o(dvalid), .dmem_ready_i(dmem_ready), .dmem_addr_o(daddr),
    .dmem_wen_o(dwen), .dmem_wstrb_o(dwstrb), .dmem_wdata_o(dwdata),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err)
  );

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) u_to (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_is_store_i(req_is_store),
    .req_load_type_i(req_load_type), .req_store_type_i(req_store_type),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .flush_i(flush),
    .busy_o(to_busy), .done_o(to_done), .load_type_o(to_load_type), .addr_lsb2_o(to_lsb2),
    .rdata_o(to_rdata), .wmask_o(to_wmask), .trap_o(to_trap), .trap_code_o(to_tcode),
    .dmem_valid_o(to_dvalid), .dmem_ready_i(dmem_ready), .dmem_addr_o(to_daddr),
    .dmem_wen_o(to_dwen), .dmem_wstrb_o(to_dwstrb), .dmem_wdata_o(to_dwdata),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [2:0] lt, input logic [1:0] stt,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_is_store = st; req_load_type = lt;
    req_store_type = stt; req_addr = a; req_wdata = d;
    #1;
  endtask

  initial begin
    #1;
    check("rst valid", 32'(dvalid), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst trap", 32'(trap), 32'h0);
    check("rst tcode", 32'(tcode), 32'h0);
    check("rst wmask", 32'(wmask), 32'h0);
    check("rst rdata", rdata, 32'h0);
    check("rst ltype", 32'(load_type), 32'h0);
    check("rst lsb2", 32'(lsb2), 32'h0);
    check("rst addr", daddr, 32'h0);
    check("rst wstrb", 32'(dwstrb), 32'h0);
    check("rst wdata", dwdata, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // sw 0x100, ready and rvalid in cycle 1
    req(1'b1, 3'b000, DMEM_STORE_SIZE_WORD, 32'h100, 32'hDEADBEEF);
    check("sw c0 busy", 32'(busy), 32'h1);
    tick();
    req_valid = 1'b0;
    check("sw c1 valid", 32'(dvalid), 32'h1);
    check("sw c1 addr", daddr, 32'h100);
    check("sw c1 wstrb", 32'(dwstrb), 32'hf);
    check("sw c1 wdata", dwdata, 32'hDEADBEEF);
    check("sw c1 wen", 32'(dwen), 32'h1);
    check("sw c1 busy", 32'(busy), 32'h1);
    dmem_ready = 1'b1; dmem_rvalid = 1'b1;
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    check("sw c2 done", 32'(done), 32'h1);
    check("sw c2 wmask", 32'(wmask), 32'hf);
    check("sw c2 trap", 32'(trap), 32'h0);
    check("sw c2 busy", 32'(busy), 32'h0);
    check("sw c2 valid", 32'(dvalid), 32'h0);
    tick();
    check("sw c3 done", 32'(done), 32'h0);
    check("sw c3 wmask hold", 32'(wmask), 32'hf);

    // sb 0x103, ready delayed three cycles
    req(1'b1, 3'b000, DMEM_STORE_SIZE_BYTE, 32'h103, 32'h000000AB);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sb valid held", 32'(dvalid), 32'h1);
      check("sb wstrb", 32'(dwstrb), 32'h8);
      check("sb wdata", dwdata, 32'hABABABAB);
      check("sb addr", daddr, 32'h100);
      if (i == 3) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    check("sb resp valid", 32'(dvalid), 32'h0);
    check("sb resp busy", 32'(busy), 32'h1);
    check("sb resp done", 32'(done), 32'h0);
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    check("sb done", 32'(done), 32'h1);
    check("sb wmask", 32'(wmask), 32'h8);
    check("sb trap", 32'(trap), 32'h0);
    tick();

    // lbu 0x201, rvalid two cycles after ready
    req(1'b0, DMEM_LOAD_SIZE_BYTEU, 2'b00, 32'h201, 32'h0);
    tick();
    req_valid = 1'b0;
    check("lbu addr", daddr, 32'h200);
    check("lbu wen", 32'(dwen), 32'h0);
    check("lbu wstrb", 32'(dwstrb), 32'h0);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
    check("lbu wait done", 32'(done), 32'h0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    check("lbu done", 32'(done), 32'h1);
    check("lbu rdata", rdata, 32'h11223344);
    check("lbu lsb2", 32'(lsb2), 32'h1);
    check("lbu ltype", 32'(load_type), 32'(DMEM_LOAD_SIZE_BYTEU));
    check("lbu wmask", 32'(wmask), 32'h0);
    tick();

    // sh 0x301: misaligned store, no bus access
    req(1'b1, 3'b000, DMEM_STORE_SIZE_HALF, 32'h301, 32'h1234);
    check("sh c0 busy", 32'(busy), 32'h1);
    tick();
    req_valid = 1'b0;
    check("sh done", 32'(done), 32'h1);
    check("sh valid", 32'(dvalid), 32'h0);
    check("sh trap", 32'(trap), 32'h1);
    check("sh tcode", 32'(tcode), 32'd6);
    check("sh wmask", 32'(wmask), 32'h0);
    tick();
    check("sh trap hold", 32'(trap), 32'h1);

    // lw 0x302: misaligned word load
    req(1'b0, DMEM_LOAD_SIZE_WORD, 2'b00, 32'h302, 32'h0);
    tick();
    req_valid = 1'b0;
    check("lw mis done", 32'(done), 32'h1);
    check("lw mis valid", 32'(dvalid), 32'h0);
    check("lw mis trap", 32'(trap), 32'h1);
    check("lw mis tcode", 32'(tcode), 32'd4);
    tick();

    // lh 0x101: misaligned half load, no trap here, zero data
    req(1'b0, DMEM_LOAD_SIZE_HALF, 2'b00, 32'h101, 32'h0);
    tick();
    req_valid = 1'b0;
    check("lh mis done", 32'(done), 32'h1);
    check("lh mis valid", 32'(dvalid), 32'h0);
    check("lh mis trap", 32'(trap), 32'h0);
    check("lh mis rdata", rdata, 32'h0);
    tick();

    // lw 0x400 with bus error
    req(1'b0, DMEM_LOAD_SIZE_WORD, 2'b00, 32'h400, 32'h0);
    tick();
    req_valid = 1'b0;
    dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'h0;
    check("lw err done", 32'(done), 32'h1);
    check("lw err trap", 32'(trap), 32'h1);
    check("lw err tcode", 32'(tcode), 32'd5);
    tick();

    // lw 0x500 flushed in RESP
    req(1'b0, DMEM_LOAD_SIZE_WORD, 2'b00, 32'h500, 32'h0);
    tick();
    req_valid = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush still busy", 32'(busy), 32'h1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    check("flush no done", 32'(done), 32'h0);
    check("flush busy drop", 32'(busy), 32'h0);
    check("flush rdata kept", rdata, 32'hCAFEF00D);
    check("flush no trap", 32'(trap), 32'h0);
    tick();
    check("flush no done later", 32'(done), 32'h0);
    tick(); tick(); tick();

    // lw 0x600, ready never given: short-timeout instance faults after 4 REQ cycles
    req(1'b0, DMEM_LOAD_SIZE_WORD, 2'b00, 32'h600, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to valid", 32'(to_dvalid), 32'h1);
      check("to no done", 32'(to_done), 32'h0);
      tick();
    end
    check("to done", 32'(to_done), 32'h1);
    check("to valid drop", 32'(to_dvalid), 32'h0);
    check("to trap", 32'(to_trap), 32'h1);
    check("to tcode", 32'(to_tcode), 32'd5);

    // the default instance is still waiting in REQ; reset it mid-transaction
    check("rst-in-req valid", 32'(dvalid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst-in-req valid drop", 32'(dvalid), 32'h0);
    check("rst-in-req busy", 32'(busy), 32'h0);
    check("rst-in-req done", 32'(done), 32'h0);
    #3 rst = 1'b0;
    tick();
    check("post-rst valid", 32'(dvalid), 32'h0);
    check("post-rst done", 32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
